// File: rtl/peak_rank_collector_pkg.sv
// Shared widths, slot/peak types and FSM encoding for the peak rank collector.
package peak_pkg;
  localparam int DATA_LEN  = 64;
  localparam int INDEX_W   = 32;
  localparam int MAX_PEAKS = 8;
  localparam int CNT_W     = 7;
  localparam int RANK_W    = (MAX_PEAKS > 1) ? $clog2(MAX_PEAKS) : 1;

  typedef struct packed {
    logic [INDEX_W-1:0]  idx;
    logic [DATA_LEN-1:0] mag;
  } peak_t;

  typedef struct packed {
    logic  valid;
    peak_t pk;
  } slot_t;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  function automatic logic [CNT_W-1:0] count_valid(input logic [MAX_PEAKS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_PEAKS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/peak_rank_collector_if.sv
// AXI-Stream beat bundle carrying the ranked {index, magnitude} list.
interface peak_rank_collector_if;
  import peak_pkg::*;
  logic [INDEX_W+DATA_LEN-1:0] tdata;
  logic                        tvalid;
  logic                        tready;
  logic                        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/peak_rank_collector_slot.sv
// One rank of the sorted collection bank: holds, takes the new peak, or takes
// the slot above when the new peak outranks an upper slot.
module peak_rank_slot
  import peak_pkg::*;
(
  input  logic  clk,
  input  logic  aresetn,
  input  peak_t i_new,
  input  logic  i_new_vld,
  input  logic  i_clear,
  input  slot_t i_upper,
  input  logic  i_upper_win,
  output slot_t o_slot,
  output slot_t o_next,
  output logic  o_win
);
  slot_t r_slot;

  // Equal magnitudes do not win, so the earlier arrival keeps the higher rank.
  always_comb begin
    o_win  = i_new_vld && (!r_slot.valid || (i_new.mag > r_slot.pk.mag));
    o_next = r_slot;
    if (o_win) begin
      if (i_upper_win) begin
        o_next = i_upper;
      end else begin
        o_next.valid = 1'b1;
        o_next.pk    = i_new;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)     r_slot <= '0;
    else if (i_clear) r_slot <= '0;
    else              r_slot <= o_next;
  end

  assign o_slot = r_slot;
endmodule

// File: rtl/peak_rank_collector.sv
// Keeps the MAX_PEAKS largest peaks of each frame and streams the ranked list
// of the previous frame out while the next frame is collected.
module peak_rank_collector
  import peak_pkg::*;
(
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [DATA_LEN-1:0]  peak_tdata,
  input  logic [INDEX_W-1:0]   peak_index,
  input  logic                 peak_tvalid,
  input  logic                 frame_last,
  peak_rank_collector_if.master m_axis,
  output logic [CNT_W-1:0]     peak_count,
  output logic                 frame_dropped
);
  peak_t                w_new;
  slot_t                w_slot [MAX_PEAKS];
  slot_t                w_next [MAX_PEAKS];
  logic                 w_win  [MAX_PEAKS];
  logic [MAX_PEAKS-1:0] w_next_vld;
  logic [CNT_W-1:0]     w_fill;

  assign w_new = {peak_index, peak_tdata};

  for (genvar g = 0; g < MAX_PEAKS; g++) begin : g_slot
    slot_t w_up;
    logic  w_up_win;
    if (g == 0) begin : g_top
      assign w_up     = '0;
      assign w_up_win = 1'b0;
    end else begin : g_chain
      assign w_up     = w_slot[g-1];
      assign w_up_win = w_win[g-1];
    end
    peak_rank_slot u_slot (
      .clk         (clk),
      .aresetn     (aresetn),
      .i_new       (w_new),
      .i_new_vld   (peak_tvalid),
      .i_clear     (frame_last),
      .i_upper     (w_up),
      .i_upper_win (w_up_win),
      .o_slot      (w_slot[g]),
      .o_next      (w_next[g]),
      .o_win       (w_win[g])
    );
    assign w_next_vld[g] = w_next[g].valid;
  end

  // Fill count after this cycle's insertion; that is what a snapshot captures.
  assign w_fill = count_valid(w_next_vld);

  state_t           r_state, w_state_nxt;
  logic [RANK_W-1:0] r_rank, w_rank_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_drop, w_drop_nxt;
  logic             w_snap, w_hs, w_last;
  peak_t            r_bank [MAX_PEAKS];

  assign w_last = (r_state == DRAIN) && (CNT_W'(r_rank) == r_count - 1'b1);
  assign w_hs   = (r_state == DRAIN) && m_axis.tready;

  always_comb begin
    w_state_nxt = r_state;
    w_rank_nxt  = r_rank;
    w_count_nxt = r_count;
    w_drop_nxt  = 1'b0;
    w_snap      = 1'b0;
    if (w_hs) begin
      if (w_last) w_state_nxt = IDLE;
      else        w_rank_nxt  = r_rank + 1'b1;
    end
    // A frame end coinciding with the final handshake is treated as idle.
    if (frame_last) begin
      if ((r_state == IDLE) || (w_hs && w_last)) begin
        w_snap      = 1'b1;
        w_count_nxt = w_fill;
        w_rank_nxt  = '0;
        w_state_nxt = (w_fill != '0) ? DRAIN : IDLE;
      end else begin
        w_drop_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_rank  <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rank  <= w_rank_nxt;
      r_count <= w_count_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_snap) begin
      for (int i = 0; i < MAX_PEAKS; i++) r_bank[i] <= w_next[i].pk;
    end
  end

  assign m_axis.tvalid = (r_state == DRAIN);
  assign m_axis.tdata  = m_axis.tvalid ? r_bank[r_rank] : '0;
  assign m_axis.tlast  = w_last;
  assign peak_count    = r_count;
  assign frame_dropped = r_drop;
endmodule
